// File: rtl/hazard_pkg.sv
// Shared types and the forwarding compare used by the pipeline hazard controller.
// Shadow stages carry only the fields needed to resolve data and load-use hazards.
package hazard_pkg;

  localparam int RF_W = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            memread;
    logic [RF_W-1:0] rd;
    logic [RF_W-1:0] rs1;
    logic [RF_W-1:0] rs2;
  } shadow_stage_t;

  localparam shadow_stage_t SHADOW_BUBBLE = '0;

  // x0 is never a forwarding source, so an unused operand (folded to 0) never matches.
  function automatic logic fwd_match(input shadow_stage_t stg, input logic [RF_W-1:0] rs);
    return stg.valid && stg.regwrite && (stg.rd != '0) && (stg.rd == rs);
  endfunction

  function automatic fwd_sel_t fwd_select(input shadow_stage_t mem,
                                          input shadow_stage_t wb,
                                          input logic [RF_W-1:0] rs);
    if (fwd_match(mem, rs))
      return FWD_MEM;
    else if (fwd_match(wb, rs))
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for debug statistics; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows EX/MEM/WB destination state to drive forwarding
// selects, load-use stalls and redirect flushes, plus saturating debug counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int RF_ADDRESS = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [RF_ADDRESS-1:0] id_rs1,
  input  logic [RF_ADDRESS-1:0] id_rs2,
  input  logic [RF_ADDRESS-1:0] id_rd,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  ex_redirect,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      retire_cnt
);

  shadow_stage_t ex_q, mem_q, wb_q, ex_d;
  logic          use_hit, stall_raw, stall, flush;
  logic          unused_wb_bits;

  assign use_hit = (id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                   (id_uses_rs2 && (id_rs2 == ex_q.rd));
  assign stall_raw = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && use_hit && id_valid;

  // A redirect means the ID instruction is on the wrong path, so it may not stall.
  assign flush = ex_redirect;
  assign stall = stall_raw && !flush && !reset;

  assign pc_en       = !stall;
  assign ifid_en     = !stall;
  assign ifid_flush  = flush;
  assign idex_bubble = stall || flush;

  assign fwd_a = 2'(fwd_select(mem_q, wb_q, ex_q.rs1));
  assign fwd_b = 2'(fwd_select(mem_q, wb_q, ex_q.rs2));

  always_comb begin
    ex_d = SHADOW_BUBBLE;
    if (id_valid && !stall && !flush) begin
      ex_d.valid    = 1'b1;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.rd       = id_rd;
      ex_d.rs1      = id_uses_rs1 ? id_rs1 : '0;
      ex_d.rs2      = id_uses_rs2 ? id_rs2 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= SHADOW_BUBBLE;
      mem_q <= SHADOW_BUBBLE;
      wb_q  <= SHADOW_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign unused_wb_bits = ^{wb_q.memread, wb_q.rs1, wb_q.rs2};

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .reset(reset), .inc(1'b1), .count(cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(stall), .count(stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(flush), .count(flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk(clk), .reset(reset), .inc(wb_q.valid), .count(retire_cnt)
  );

endmodule
